// File: rtl/pcie_pkg.sv
// Shared PCIe TLP definitions for the RX disassembler: header field layout,
// Completion Fmt/Type codes and the Length-to-beats helper.
package pcie_pkg;

  localparam int PIPE_DATA_WIDTH = 256;

  localparam logic [2:0] FMT_CPL  = 3'b000;
  localparam logic [2:0] FMT_CPLD = 3'b010;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [13:0] mid;
    logic [9:0]  length;
  } tlp_hdr_dw0_t;

  // Length 0 encodes 1024 DW; 8 DW per beat gives 1..128 beats.
  function automatic logic [7:0] beats_from_len(input logic [9:0] len);
    logic [10:0] dw;
    dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    return 8'((dw + 11'd7) >> 3);
  endfunction

endpackage

// File: rtl/tlp_disassembler.sv
// RX TLP splitter: Completion headers to the CPL header FIFO, CplD payload to the
// payload FIFO, everything else drained. Optional counters under TLP_DISASM_STATS_EN.
module tlp_disassembler
  import pcie_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = PIPE_DATA_WIDTH,
  parameter int BEAT_CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tlp_in_valid,
  output logic                     tlp_in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] tlp_in_data,
  input  logic                     tlp_in_last,
  input  logic                     cpl_hdr_fifo_full,
  output logic                     cpl_hdr_fifo_wren,
  output logic [127:0]             cpl_hdr_fifo_data,
  input  logic                     cpl_pay_fifo_full,
  output logic                     cpl_pay_fifo_wren,
  output logic [PAYLOAD_WIDTH-1:0] cpl_pay_fifo_data,
  output logic                     cpl_pay_fifo_last,
  output logic                     err_len_pulse,
  output logic                     drop_pulse
`ifdef TLP_DISASM_STATS_EN
  ,
  output logic [15:0]              stat_cpl_cnt,
  output logic [15:0]              stat_drop_cnt,
  output logic [15:0]              stat_err_cnt
`endif
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

  state_t                state, state_n;
  logic [BEAT_CNT_W-1:0] cnt, cnt_n;
  logic                  rdy, acc;
  tlp_hdr_dw0_t          dw0;
  logic [13:0]           dw0_unused_mid;
  logic                  is_cpl, is_cpld;

  assign dw0            = tlp_in_data[PAYLOAD_WIDTH-1 -: 32];
  assign dw0_unused_mid = dw0.mid;
  assign is_cpl         = (dw0.fmt == FMT_CPL)  && (dw0.typ == TYPE_CPL);
  assign is_cpld        = (dw0.fmt == FMT_CPLD) && (dw0.typ == TYPE_CPL);

  assign cpl_hdr_fifo_data = tlp_in_data[PAYLOAD_WIDTH-1 -: 128];
  assign cpl_pay_fifo_data = tlp_in_data;
  // Reset overrides ready so a partially received TLP is simply abandoned.
  assign tlp_in_ready      = rst_n & rdy;

  always_comb begin
    rdy               = 1'b0;
    acc               = 1'b0;
    state_n           = state;
    cnt_n             = cnt;
    cpl_hdr_fifo_wren = 1'b0;
    cpl_pay_fifo_wren = 1'b0;
    cpl_pay_fifo_last = 1'b0;
    err_len_pulse     = 1'b0;
    drop_pulse        = 1'b0;
    case (state)
      S_HDR: begin
        rdy = !cpl_hdr_fifo_full;
        acc = tlp_in_valid & rdy & rst_n;
        if (acc) begin
          if (is_cpl) begin
            cpl_hdr_fifo_wren = 1'b1;
            if (!tlp_in_last) begin
              err_len_pulse = 1'b1;
              state_n       = S_DROP;
            end
          end else if (is_cpld) begin
            cpl_hdr_fifo_wren = 1'b1;
            cnt_n             = BEAT_CNT_W'(beats_from_len(dw0.length));
            if (tlp_in_last) err_len_pulse = 1'b1;
            else             state_n       = S_PAY;
          end else begin
            drop_pulse = 1'b1;
            if (!tlp_in_last) state_n = S_DROP;
          end
        end
      end
      S_PAY: begin
        rdy = !cpl_pay_fifo_full;
        acc = tlp_in_valid & rdy & rst_n;
        if (acc) begin
          cpl_pay_fifo_wren = 1'b1;
          cpl_pay_fifo_last = (cnt == BEAT_CNT_W'(1)) | tlp_in_last;
          cnt_n             = cnt - BEAT_CNT_W'(1);
          if (tlp_in_last) begin
            err_len_pulse = (cnt != BEAT_CNT_W'(1));
            state_n       = S_HDR;
          end else if (cnt == BEAT_CNT_W'(1)) begin
            // Length satisfied but the TLP keeps going: discard the excess.
            err_len_pulse = 1'b1;
            state_n       = S_DROP;
          end
        end
      end
      S_DROP: begin
        rdy = 1'b1;
        acc = tlp_in_valid & rst_n;
        if (acc && tlp_in_last) state_n = S_HDR;
      end
      default: state_n = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HDR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef TLP_DISASM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpl_cnt  <= '0;
      stat_drop_cnt <= '0;
      stat_err_cnt  <= '0;
    end else begin
      if (cpl_hdr_fifo_wren && stat_cpl_cnt  != 16'hFFFF) stat_cpl_cnt  <= stat_cpl_cnt  + 16'd1;
      if (drop_pulse        && stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
      if (err_len_pulse     && stat_err_cnt  != 16'hFFFF) stat_err_cnt  <= stat_err_cnt  + 16'd1;
    end
  end
`endif

endmodule
